// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU packet processor
// Optional feature macro: ALU_ERR_RESP_EN (adds the ST_ERR state).
package alu_pkg;

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hA0,
    OP_MUL  = 8'hA1
  } opcode_e;

  typedef enum logic [3:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_ECHO,
    ST_OPERAND,
    ST_RESULT,
    ST_DRAIN
`ifdef ALU_ERR_RESP_EN
    ,
    ST_ERR
`endif
  } state_e;

  localparam int         HDR_BYTES     = 4;
  localparam int         OPERAND_BYTES = 4;
  localparam logic [7:0] ERR_BYTE      = 8'hEE;

endpackage

// File: rtl/alu_packet_proc_if.sv
// rtl/alu_packet_proc_if.sv - byte stream bundle (tdata/tvalid/tready)
// Signals: tdata  - stream byte
//          tvalid - byte valid (driven by master)
//          tready - byte accepted (driven by slave)
interface alu_packet_proc_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/alu_accum.sv
// rtl/alu_accum.sv - combinational 32-bit add/mul accumulator step
// Ports: op_i      - opcode of the current packet (mul selects product, else sum)
//        acc_i     - current accumulator
//        operand_i - newly assembled little-endian operand
//        acc_o     - next accumulator value (32-bit wrap-around)
module alu_accum
  import alu_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [31:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [31:0] acc_o
);

  always_comb begin
    acc_o = acc_i + operand_i;
    if (op_i == OP_MUL) begin
      acc_o = acc_i * operand_i;
    end
  end

endmodule

// File: rtl/alu_packet_proc.sv
// rtl/alu_packet_proc.sv - framed command packet parser with echo/add32/mul32
// Optional feature macro: ALU_ERR_RESP_EN (unknown opcode answers with one 0xEE byte).
// Ports: clk_i, rst_ni - clock, asynchronous active-low reset
//        s_axis        - incoming command bytes (slave)
//        m_axis        - outgoing response bytes (master)
//        busy_o        - high whenever the parser is not waiting for an opcode
module alu_packet_proc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  alu_packet_proc_if.slave   s_axis,
  alu_packet_proc_if.master  m_axis,
  output logic               busy_o
);

  state_e                      state_q, state_d;
  logic [31:0]                 acc_q, acc_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic [3*DATA_WIDTH-1:0]     hold_q, hold_d;
  logic [1:0]                  byte_idx_q, byte_idx_d;
  logic [1:0]                  res_idx_q, res_idx_d;
  logic [7:0]                  op_q, op_d;

  logic [31:0]                 acc_next;
  logic [LEN_WIDTH-1:0]        len_w;
  logic [LEN_WIDTH-1:0]        payload_w;
  logic                        s_tready;
  logic                        m_tvalid;
  logic [DATA_WIDTH-1:0]       m_tdata;

  alu_accum u_accum (
    .op_i      (op_q),
    .acc_i     (acc_q),
    .operand_i ({s_axis.tdata, hold_q}),
    .acc_o     (acc_next)
  );

  // Length LSB is parked in cnt_q during LEN_LO so the full length is
  // available combinationally at the LEN_HI handshake.
  assign len_w     = LEN_WIDTH'({s_axis.tdata, cnt_q[DATA_WIDTH-1:0]});
  assign payload_w = (len_w > LEN_WIDTH'(HDR_BYTES)) ? len_w - LEN_WIDTH'(HDR_BYTES) : '0;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    byte_idx_d = byte_idx_q;
    res_idx_d  = res_idx_q;
    op_d       = op_q;
    s_tready   = 1'b1;
    m_tvalid   = 1'b0;
    m_tdata    = '0;

    case (state_q)
      ST_OPCODE: begin
        if (s_axis.tvalid) begin
          op_d    = s_axis.tdata;
          state_d = ST_RSVD;
        end
      end
      ST_RSVD: begin
        if (s_axis.tvalid) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (s_axis.tvalid) begin
          cnt_d   = LEN_WIDTH'(s_axis.tdata);
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (s_axis.tvalid) begin
          cnt_d      = payload_w;
          acc_d      = (op_q == OP_MUL) ? 32'd1 : 32'd0;
          hold_d     = '0;
          byte_idx_d = '0;
          res_idx_d  = '0;
          if (op_q == OP_ECHO) begin
            state_d = (payload_w == '0) ? ST_OPCODE : ST_ECHO;
          end else if (op_q == OP_ADD || op_q == OP_MUL) begin
            state_d = (payload_w == '0) ? ST_RESULT : ST_OPERAND;
          end else if (payload_w != '0) begin
            state_d = ST_DRAIN;
          end else begin
`ifdef ALU_ERR_RESP_EN
            state_d = ST_ERR;
`else
            state_d = ST_OPCODE;
`endif
          end
        end
      end
      ST_ECHO: begin
        // Pure passthrough: the transmitter's ready throttles the receiver.
        s_tready = m_axis.tready;
        m_tvalid = s_axis.tvalid;
        m_tdata  = s_axis.tdata;
        if (s_axis.tvalid && m_axis.tready) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= LEN_WIDTH'(1)) state_d = ST_OPCODE;
        end
      end
      ST_OPERAND: begin
        if (s_axis.tvalid) begin
          cnt_d = cnt_q - 1'b1;
          if (byte_idx_q == 2'(OPERAND_BYTES - 1)) begin
            acc_d      = acc_next;
            byte_idx_d = '0;
          end else begin
            // Little-endian: newest byte enters at the top and slides down.
            hold_d     = {s_axis.tdata, hold_q[3*DATA_WIDTH-1:DATA_WIDTH]};
            byte_idx_d = byte_idx_q + 1'b1;
          end
          if (cnt_q <= LEN_WIDTH'(1)) state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        s_tready = 1'b0;
        m_tvalid = 1'b1;
        case (res_idx_q)
          2'd0:    m_tdata = acc_q[7:0];
          2'd1:    m_tdata = acc_q[15:8];
          2'd2:    m_tdata = acc_q[23:16];
          default: m_tdata = acc_q[31:24];
        endcase
        if (m_axis.tready) begin
          res_idx_d = res_idx_q + 1'b1;
          if (res_idx_q == 2'd3) state_d = ST_OPCODE;
        end
      end
      ST_DRAIN: begin
        if (s_axis.tvalid) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= LEN_WIDTH'(1)) begin
`ifdef ALU_ERR_RESP_EN
            state_d = ST_ERR;
`else
            state_d = ST_OPCODE;
`endif
          end
        end
      end
`ifdef ALU_ERR_RESP_EN
      ST_ERR: begin
        s_tready = 1'b0;
        m_tvalid = 1'b1;
        m_tdata  = ERR_BYTE;
        if (m_axis.tready) state_d = ST_OPCODE;
      end
`endif
      default: state_d = ST_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_OPCODE;
      acc_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      byte_idx_q <= '0;
      res_idx_q  <= '0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      byte_idx_q <= byte_idx_d;
      res_idx_q  <= res_idx_d;
      op_q       <= op_d;
    end
  end

  assign s_axis.tready = s_tready;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tdata  = m_tdata;
  assign busy_o        = (state_q != ST_OPCODE);

endmodule

// File: tb/tb_alu_packet_proc.sv
// tb/tb_alu_packet_proc.sv - directed self-checking bench for alu_packet_proc
module tb_alu_packet_proc;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   failures;

  alu_packet_proc_if #(.DATA_WIDTH(8)) s_if ();
  alu_packet_proc_if #(.DATA_WIDTH(8)) m_if ();

  alu_packet_proc #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .s_axis (s_if.slave),
    .m_axis (m_if.master),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    s_if.tdata  = b;
    s_if.tvalid = 1'b1;
    #1;
    while (!s_if.tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(s_if.tready), 32'd1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  // Echo payload byte: the same byte must appear on the output combinationally.
  task automatic send_echo(input logic [7:0] b, input string tag);
    s_if.tdata  = b;
    s_if.tvalid = 1'b1;
    #1;
    check({tag, "_tvalid"}, 32'(m_if.tvalid), 32'd1);
    check({tag, "_tdata"}, 32'(m_if.tdata), 32'(b));
    send(b);
  endtask

  task automatic recv(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    m_if.tready = 1'b1;
    while (!m_if.tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tvalid"}, 32'(m_if.tvalid), 32'd1);
    check(tag, 32'(m_if.tdata), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, "_no_tvalid"}, 32'(m_if.tvalid), 32'd0);
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_tready", 32'(s_if.tready), 32'd1);
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Echo 41 42 43
    send(8'hEC); send(8'h00); send(8'h07); send(8'h00);
    send_echo(8'h41, "echo0");
    send_echo(8'h42, "echo1");
    send_echo(8'h43, "echo2");
    check("echo_busy_after", 32'(busy), 32'd0);

    // Zero-length echo
    send(8'hEC); send(8'h00); send(8'h00); send(8'h00);
    check("echo_len0_busy", 32'(busy), 32'd0);

    // Add 1 + 2 = 3
    send(8'hA0); send(8'h00); send(8'h0C); send(8'h00);
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    check("add_latency_tvalid", 32'(m_if.tvalid), 32'd1);
    recv(8'h03, "add_b0"); recv(8'h00, "add_b1");
    recv(8'h00, "add_b2"); recv(8'h00, "add_b3");
    check("add_busy_after", 32'(busy), 32'd0);

    // Mul wrap: FFFFFFFF * 2 = FFFFFFFE
    send(8'hA1); send(8'h00); send(8'h0C); send(8'h00);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    recv(8'hFE, "mul_b0"); recv(8'hFF, "mul_b1");
    recv(8'hFF, "mul_b2"); recv(8'hFF, "mul_b3");

    // Mul 3 * 5 with a 3-byte trailing partial operand discarded
    send(8'hA1); send(8'h00); send(8'h0F); send(8'h00);
    send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    send(8'h05); send(8'h00); send(8'h00); send(8'h00);
    send(8'h07); send(8'h00); send(8'h00);
    recv(8'h0F, "mulp_b0"); recv(8'h00, "mulp_b1");
    recv(8'h00, "mulp_b2"); recv(8'h00, "mulp_b3");

    // Add with length 4: no payload, result 0 the cycle after LEN_HI
    send(8'hA0); send(8'h00); send(8'h04); send(8'h00);
    check("add0_latency_tvalid", 32'(m_if.tvalid), 32'd1);
    recv(8'h00, "add0_b0"); recv(8'h00, "add0_b1");
    recv(8'h00, "add0_b2"); recv(8'h00, "add0_b3");

    // Result backpressure: 04030201 + 10101010 = 14131211, stall on byte 1
    send(8'hA0); send(8'h00); send(8'h0C); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h10); send(8'h10); send(8'h10); send(8'h10);
    recv(8'h11, "bp_b0");
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_tdata", 32'(m_if.tdata), 32'h12);
      check("bp_hold_tvalid", 32'(m_if.tvalid), 32'd1);
      check("bp_hold_s_tready", 32'(s_if.tready), 32'd0);
    end
    s_if.tvalid = 1'b0;
    recv(8'h12, "bp_b1"); recv(8'h13, "bp_b2"); recv(8'h14, "bp_b3");

    // Echo backpressure: transmitter not ready stalls the receiver
    send(8'hEC); send(8'h00); send(8'h05); send(8'h00);
    m_if.tready = 1'b0;
    s_if.tdata  = 8'h99;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    check("echo_bp_s_tready", 32'(s_if.tready), 32'd0);
    check("echo_bp_m_tvalid", 32'(m_if.tvalid), 32'd1);
    m_if.tready = 1'b1;
    send_echo(8'h99, "echo_bp");
    check("echo_bp_busy_after", 32'(busy), 32'd0);

    // Unknown opcode: both payload bytes consumed
    send(8'h55); send(8'h00); send(8'h06); send(8'h00);
    send(8'hAA); send(8'hBB);
`ifdef ALU_ERR_RESP_EN
    recv(8'hEE, "unk_err");
    check("unk_busy_after", 32'(busy), 32'd0);
`else
    expect_idle(4, "unk");
`endif

    // Reset mid-packet, then a clean echo
    send(8'hA0); send(8'h00); send(8'h0C); send(8'h00); send(8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_tready", 32'(s_if.tready), 32'd1);
    check("mid_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("mid_rst_m_tdata", 32'(m_if.tdata), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hEC); send(8'h00); send(8'h05); send(8'h00);
    send_echo(8'h77, "post_rst_echo");
    expect_idle(6, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
